bpred_btb: RTL and testbench

- Parametrised branch predictor for the 5-stage pipeline: a direct-mapped branch target buffer (BTB) with one 2-bit saturating counter per entry.
- Lookup is combinational in IF, indexed by the PC register output; it supplies the predicted next PC to the address mux.
- Update is synchronous, driven from EX/MEM branch resolution; on a wrong prediction it flags a mispredict to the flush/redirect logic.
- Replaces the fixed "predict not-taken, flush on taken" scheme.

---
 rtl/bpred_btb_pkg.sv | 34 +++
 rtl/bpred_btb_sat_counter.sv | 24 ++
 rtl/bpred_btb.sv | 178 +++++++++++++++++
 tb/tb_bpred_btb.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bpred_btb_pkg.sv
// Shared constants and PC field helpers for the BTB predictor.
// Counter encodings, PC step and index/tag extraction live here.
package bpred_btb_pkg;

  localparam logic [1:0] SN = 2'b00;
  localparam logic [1:0] WN = 2'b01;
  localparam logic [1:0] WT = 2'b10;
  localparam logic [1:0] ST = 2'b11;

  localparam int PC_STEP = 4;

  // Widest PC the helpers accept; callers cast down.
  localparam int MAX_W = 64;

  function automatic logic [MAX_W-1:0] pcIndex(
    input logic [MAX_W-1:0] pc,
    input int               idxW
  );
    logic [MAX_W-1:0] mask;
    mask = (MAX_W'(1) << idxW) - MAX_W'(1);
    return (pc >> 2) & mask;
  endfunction

  function automatic logic [MAX_W-1:0] pcTag(
    input logic [MAX_W-1:0] pc,
    input int               idxW,
    input int               tagW
  );
    logic [MAX_W-1:0] mask;
    mask = (MAX_W'(1) << tagW) - MAX_W'(1);
    return (pc >> (idxW + 2)) & mask;
  endfunction

endpackage

// File: rtl/bpred_btb_sat_counter.sv
// Width-parametrised saturating up/down counter next-state.
// Holds at all-ones going up and at zero going down.
module sat_counter #(
  parameter int W = 2
) (
  input  logic [W-1:0] cnt,
  input  logic         en,
  input  logic         up,
  output logic [W-1:0] nxt
);

  // Step toward the requested rail, stop at the rail.
  always_comb begin
    nxt = cnt;
    if (en) begin
      if (up && (cnt != '1)) begin
        nxt = cnt + W'(1);
      end else if (!up && (cnt != '0)) begin
        nxt = cnt - W'(1);
      end
    end
  end

endmodule

// File: rtl/bpred_btb.sv
// Direct-mapped BTB with per-entry saturating counters.
// Optional perf counters under BPRED_PERF_EN.
module bpred_btb
  import bpred_btb_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int ADDR_W  = 32,
  parameter int TAG_W   = 8,
  parameter int CTR_W   = 2
) (
  input  logic              clkIn,
  input  logic              resetIn,
  input  logic [ADDR_W-1:0] lookup_pc_i,
  output logic              pred_hit_o,
  output logic              pred_taken_o,
  output logic [ADDR_W-1:0] pred_target_o,
  input  logic              update_en_i,
  input  logic [ADDR_W-1:0] update_pc_i,
  input  logic              update_taken_i,
  input  logic [ADDR_W-1:0] update_target_i,
  input  logic              update_pred_taken_i,
  input  logic [ADDR_W-1:0] update_pred_target_i,
  output logic              mispredict_o,
  input  logic              flush_all_i,
  output logic [31:0]       branch_cnt_o,
  output logic [31:0]       mispred_cnt_o
);

  localparam int IDX_W = $clog2(ENTRIES);

  localparam logic [CTR_W-1:0] CTR_RST =
    CTR_W'(WN);
  localparam logic [CTR_W-1:0] CTR_ALLOC =
    CTR_W'(1 << (CTR_W - 1));

  if ((ENTRIES < 2) || ((1 << IDX_W) != ENTRIES)) begin : gBadEntries
    $error("ENTRIES must be a power of 2, at least 2");
  end
  if ((IDX_W + 2 + TAG_W) > ADDR_W) begin : gBadTag
    $error("IDX_W + 2 + TAG_W exceeds ADDR_W");
  end

  logic [ENTRIES-1:0] vld;
  logic [TAG_W-1:0]   tagArr [ENTRIES];
  logic [ADDR_W-1:0]  tgtArr [ENTRIES];
  logic [CTR_W-1:0]   ctrArr [ENTRIES];

  logic [IDX_W-1:0]  lkIdx;
  logic [TAG_W-1:0]  lkTag;
  logic              lkHit;
  logic              lkTaken;
  logic [ADDR_W-1:0] lkTarget;

  logic [IDX_W-1:0]  updIdx;
  logic [TAG_W-1:0]  updTag;
  logic              updHit;
  logic [CTR_W-1:0]  updCtr;
  logic [CTR_W-1:0]  updCtrNxt;
  logic              mispredRaw;

  assign lkIdx  = IDX_W'(pcIndex(MAX_W'(lookup_pc_i), IDX_W));
  assign lkTag  = TAG_W'(pcTag(MAX_W'(lookup_pc_i), IDX_W, TAG_W));
  assign updIdx = IDX_W'(pcIndex(MAX_W'(update_pc_i), IDX_W));
  assign updTag = TAG_W'(pcTag(MAX_W'(update_pc_i), IDX_W, TAG_W));

  // IF-side read: pre-update contents, no bypass from the write port.
  always_comb begin
    lkHit    = vld[lkIdx] && (tagArr[lkIdx] == lkTag);
    lkTaken  = lkHit && ctrArr[lkIdx][CTR_W-1];
    lkTarget = lookup_pc_i + ADDR_W'(PC_STEP);
    if (lkTaken) begin
      lkTarget = tgtArr[lkIdx];
    end
  end

  // Outputs read as zero for as long as reset is held.
  assign pred_hit_o    = resetIn & lkHit;
  assign pred_taken_o  = resetIn & lkTaken;
  assign pred_target_o = resetIn ? lkTarget : '0;

  // Direction or target of the resolved branch differs from the guess.
  always_comb begin
    mispredRaw = 1'b0;
    if (update_en_i) begin
      mispredRaw =
        (update_pred_taken_i != update_taken_i) ||
        (update_taken_i &&
         (update_pred_target_i != update_target_i));
    end
  end

  assign mispredict_o = resetIn & mispredRaw;

  assign updHit = vld[updIdx] && (tagArr[updIdx] == updTag);
  assign updCtr = ctrArr[updIdx];

  sat_counter #(
    .W(CTR_W)
  ) uEntryCtr (
    .cnt(updCtr),
    .en (1'b1),
    .up (update_taken_i),
    .nxt(updCtrNxt)
  );

  // Table write port: reset, flush-all, then resolved-branch update.
  always_ff @(posedge clkIn or negedge resetIn) begin
    if (!resetIn) begin
      vld <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tagArr[i] <= '0;
        tgtArr[i] <= '0;
        ctrArr[i] <= CTR_RST;
      end
    end else if (flush_all_i) begin
      vld <= '0;
    end else if (update_en_i) begin
      if (updHit) begin
        ctrArr[updIdx] <= updCtrNxt;
        if (update_taken_i) begin
          tgtArr[updIdx] <= update_target_i;
        end
      end else if (update_taken_i) begin
        vld[updIdx]    <= 1'b1;
        tagArr[updIdx] <= updTag;
        tgtArr[updIdx] <= update_target_i;
        ctrArr[updIdx] <= CTR_ALLOC;
      end
    end
  end

`ifdef BPRED_PERF_EN

  logic [31:0] branchCnt;
  logic [31:0] mispredCnt;
  logic [31:0] branchCntNxt;
  logic [31:0] mispredCntNxt;

  sat_counter #(
    .W(32)
  ) uBranchCnt (
    .cnt(branchCnt),
    .en (update_en_i),
    .up (1'b1),
    .nxt(branchCntNxt)
  );

  sat_counter #(
    .W(32)
  ) uMispredCnt (
    .cnt(mispredCnt),
    .en (mispredRaw),
    .up (1'b1),
    .nxt(mispredCntNxt)
  );

  // Perf counters survive flush-all; only reset clears them.
  always_ff @(posedge clkIn or negedge resetIn) begin
    if (!resetIn) begin
      branchCnt  <= '0;
      mispredCnt <= '0;
    end else begin
      branchCnt  <= branchCntNxt;
      mispredCnt <= mispredCntNxt;
    end
  end

  assign branch_cnt_o  = branchCnt;
  assign mispred_cnt_o = mispredCnt;

`else

  assign branch_cnt_o  = '0;
  assign mispred_cnt_o = '0;

`endif

endmodule

// File: tb/tb_bpred_btb.sv
// Randomised self-checking bench for bpred_btb.
// Reference model is a plain array table with integer counters.
module tb_bpred_btb;

  localparam int ENTRIES = 16;
  localparam int ADDR_W  = 32;
  localparam int TAG_W   = 8;
  localparam int CTR_W   = 2;
  localparam int IDX_W   = 4;

`ifdef BPRED_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rstn;
  logic [ADDR_W-1:0] lookupPc;
  logic              predHit;
  logic              predTaken;
  logic [ADDR_W-1:0] predTarget;
  logic              updEn;
  logic [ADDR_W-1:0] updPc;
  logic              updTaken;
  logic [ADDR_W-1:0] updTarget;
  logic              updPredTaken;
  logic [ADDR_W-1:0] updPredTarget;
  logic              mispredict;
  logic              flushAll;
  logic [31:0]       branchCnt;
  logic [31:0]       mispredCnt;

  always #5 clk = ~clk;

  bpred_btb #(
    .ENTRIES(ENTRIES),
    .ADDR_W (ADDR_W),
    .TAG_W  (TAG_W),
    .CTR_W  (CTR_W)
  ) dut (
    .clkIn               (clk),
    .resetIn             (rstn),
    .lookup_pc_i         (lookupPc),
    .pred_hit_o          (predHit),
    .pred_taken_o        (predTaken),
    .pred_target_o       (predTarget),
    .update_en_i         (updEn),
    .update_pc_i         (updPc),
    .update_taken_i      (updTaken),
    .update_target_i     (updTarget),
    .update_pred_taken_i (updPredTaken),
    .update_pred_target_i(updPredTarget),
    .mispredict_o        (mispredict),
    .flush_all_i         (flushAll),
    .branch_cnt_o        (branchCnt),
    .mispred_cnt_o       (mispredCnt)
  );

  bit          mVld [ENTRIES];
  int unsigned mTag [ENTRIES];
  logic [31:0] mTgt [ENTRIES];
  int          mCtr [ENTRIES];
  longint      mBr;
  longint      mMis;

  int nChecks = 0;
  int nFail   = 0;

  logic        obsHit;
  logic        obsTaken;
  logic [31:0] obsTgt;
  logic        obsMis;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void mReset();
    for (int i = 0; i < ENTRIES; i++) begin
      mVld[i] = 1'b0;
      mTag[i] = 0;
      mTgt[i] = '0;
      mCtr[i] = 1;
    end
    mBr  = 0;
    mMis = 0;
  endfunction

  function automatic int idxOf(input logic [31:0] pc);
    return int'((pc / 4) % ENTRIES);
  endfunction

  function automatic int unsigned tagOf(input logic [31:0] pc);
    return (pc / (4 * ENTRIES)) % (1 << TAG_W);
  endfunction

  function automatic void mPredict(input  logic [31:0] pc,
                                   output bit          hit,
                                   output bit          tk,
                                   output logic [31:0] tgt);
    int i;
    i   = idxOf(pc);
    hit = mVld[i] && (mTag[i] == tagOf(pc));
    tk  = hit && (mCtr[i] >= (1 << (CTR_W - 1)));
    tgt = tk ? mTgt[i] : pc + 32'd4;
  endfunction

  function automatic longint satInc(input longint v);
    return (v >= 64'hFFFF_FFFF) ? v : v + 1;
  endfunction

  task automatic cycle(input bit en, input logic [31:0] upc,
                       input bit tk, input logic [31:0] tgt,
                       input bit pt, input logic [31:0] ptgt,
                       input bit fl, input logic [31:0] lpc);
    bit          eHit, eTaken, eMis;
    logic [31:0] eTgt;
    int          i;
    @(negedge clk);
    lookupPc      = lpc;
    updEn         = en;
    updPc         = upc;
    updTaken      = tk;
    updTarget     = tgt;
    updPredTaken  = pt;
    updPredTarget = ptgt;
    flushAll      = fl;
    #1;
    mPredict(lpc, eHit, eTaken, eTgt);
    eMis = en && ((pt != tk) || (tk && (ptgt != tgt)));
    chk("hit", predHit, eHit);
    chk("taken", predTaken, eTaken);
    chk("target", predTarget, eTgt);
    chk("mispredict", mispredict, eMis);
    chk("branch_cnt", branchCnt, PERF ? mBr : 0);
    chk("mispred_cnt", mispredCnt, PERF ? mMis : 0);
    obsHit   = predHit;
    obsTaken = predTaken;
    obsTgt   = predTarget;
    obsMis   = mispredict;
    @(posedge clk);
    if (en) mBr = satInc(mBr);
    if (eMis) mMis = satInc(mMis);
    i = idxOf(upc);
    if (fl) begin
      for (int k = 0; k < ENTRIES; k++) mVld[k] = 1'b0;
    end else if (en) begin
      if (mVld[i] && (mTag[i] == tagOf(upc))) begin
        if (tk) begin
          mCtr[i] = (mCtr[i] < (1 << CTR_W) - 1) ? mCtr[i] + 1 : mCtr[i];
          mTgt[i] = tgt;
        end else begin
          mCtr[i] = (mCtr[i] > 0) ? mCtr[i] - 1 : 0;
        end
      end else if (tk) begin
        mVld[i] = 1'b1;
        mTag[i] = tagOf(upc);
        mTgt[i] = tgt;
        mCtr[i] = 1 << (CTR_W - 1);
      end
    end
  endtask

  task automatic idle(input logic [31:0] lpc);
    cycle(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, lpc);
  endtask

  task automatic upd(input logic [31:0] pc, input bit tk,
                     input logic [31:0] tgt);
    cycle(1'b1, pc, tk, tgt, 1'b0, pc + 32'd4, 1'b0, pc);
  endtask

  task automatic quiet();
    updEn         = 1'b0;
    updPc         = '0;
    updTaken      = 1'b0;
    updTarget     = '0;
    updPredTaken  = 1'b0;
    updPredTarget = '0;
    flushAll      = 1'b0;
  endtask

  task automatic checkZeroOut(input string tag);
    chk({tag, "_hit"}, predHit, 0);
    chk({tag, "_taken"}, predTaken, 0);
    chk({tag, "_target"}, predTarget, 0);
    chk({tag, "_mispredict"}, mispredict, 0);
    chk({tag, "_branch_cnt"}, branchCnt, 0);
    chk({tag, "_mispred_cnt"}, mispredCnt, 0);
  endtask

  task automatic resetPulse();
    @(negedge clk);
    #2;
    lookupPc      = 32'h40;
    updEn         = 1'b1;
    updPredTaken  = 1'b1;
    updTaken      = 1'b0;
    rstn          = 1'b0;
    #1;
    checkZeroOut("async_rst");
    mReset();
    quiet();
    @(negedge clk);
    #2;
    rstn = 1'b1;
  endtask

  function automatic logic [31:0] randPc();
    logic [31:0] pc;
    int          sel;
    sel = $urandom_range(0, 3);
    pc  = {$urandom_range(0, 15), 2'($urandom_range(0, 3))};
    pc  = (pc & 32'h3F) |
          (32'((sel == 3) ? 255 : sel) << 6);
    if ($urandom_range(0, 3) == 0) begin
      pc = pc | ($urandom & 32'hFFFF_C000);
    end
    return pc;
  endfunction

  initial begin
    bit          pHit, pTk, tk, en, fl;
    logic [31:0] pTgt, upc, tgt, ptgt, lpc;
    bit          pt;

    rstn     = 1'b0;
    lookupPc = 32'h40;
    quiet();
    updEn        = 1'b1;
    updPredTaken = 1'b1;
    mReset();
    #1;
    checkZeroOut("reset");
    quiet();
    #20;
    @(negedge clk);
    #2;
    rstn = 1'b1;

    idle(32'h40);
    chk("tp_rst_hit", obsHit, 0);
    chk("tp_rst_tgt", obsTgt, 32'h44);
    chk("tp_rst_mis", obsMis, 0);

    upd(32'h40, 1'b1, 32'h100);
    idle(32'h40);
    chk("tp_alloc_hit", obsHit, 1);
    chk("tp_alloc_taken", obsTaken, 1);
    chk("tp_alloc_tgt", obsTgt, 32'h100);
    idle(32'h440);
    chk("tp_alias_hit", obsHit, 0);

    upd(32'h40, 1'b1, 32'h100);
    upd(32'h40, 1'b1, 32'h100);
    idle(32'h40);
    chk("tp_st_taken", obsTaken, 1);
    upd(32'h40, 1'b0, '0);
    upd(32'h40, 1'b0, '0);
    idle(32'h40);
    chk("tp_wn_taken", obsTaken, 0);
    upd(32'h40, 1'b0, '0);
    upd(32'h40, 1'b0, '0);
    upd(32'h40, 1'b1, 32'h100);
    idle(32'h40);
    chk("tp_sn_sat", obsTaken, 0);

    cycle(1'b1, 32'h80, 1'b1, 32'h200, 1'b0, 32'h84, 1'b0, 32'h80);
    chk("tp_same_cyc_hit", obsHit, 0);
    idle(32'h80);
    chk("tp_next_cyc_hit", obsHit, 1);

    resetPulse();
    idle(32'h80);
    chk("tp_post_rst_hit", obsHit, 0);

    cycle(1'b1, 32'h40, 1'b1, 32'h104, 1'b1, 32'h100, 1'b0, 32'h40);
    chk("tp_mis_tgt", obsMis, 1);
    cycle(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 32'h44, 1'b0, 32'h40);
    chk("tp_mis_none", obsMis, 0);
    idle(32'h40);
    chk("tp_br_cnt", branchCnt, PERF ? 2 : 0);
    chk("tp_mis_cnt", mispredCnt, PERF ? 1 : 0);

    upd(32'h80, 1'b1, 32'h200);
    cycle(1'b1, 32'hC0, 1'b1, 32'h300, 1'b0, 32'hC4, 1'b1, 32'hC0);
    idle(32'hC0);
    chk("tp_flush_c0", obsHit, 0);
    idle(32'h40);
    chk("tp_flush_40", obsHit, 0);
    idle(32'h80);
    chk("tp_flush_80", obsHit, 0);
    chk("tp_flush_cnt", branchCnt, PERF ? 4 : 0);

    idle(32'hFFFF_FFFE);
    chk("tp_wrap_tgt", obsTgt, 32'h2);

    for (int n = 0; n < 1500; n++) begin
      if (n == 700) resetPulse();
      upc = randPc();
      en  = ($urandom_range(0, 3) != 0);
      tk  = $urandom_range(0, 1);
      tgt = {$urandom_range(0, 255), 2'b00};
      mPredict(upc, pHit, pTk, pTgt);
      if ($urandom_range(0, 1) == 1) begin
        pt   = pTk;
        ptgt = pTgt;
      end else begin
        pt   = $urandom_range(0, 1);
        ptgt = {$urandom_range(0, 255), 2'b00};
      end
      fl  = ($urandom_range(0, 63) == 0);
      lpc = ($urandom_range(0, 1) == 1) ? upc : randPc();
      cycle(en, upc, tk, tgt, pt, ptgt, fl, lpc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             nChecks, nFail);
    $finish;
  end

endmodule
